muldiv_ctrl: RTL



---
 rtl/muldiv_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/muldiv_ctrl.sv
// Multicycle multiply/divide sequencer for MIPS mult/multu/div/divu.
// Iterates one bit per cycle on unsigned magnitudes, then applies signs and writes HI/LO.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] qp_q, qp_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             is_signed_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_diff;
  logic             rem_ge;
  logic [2*WIDTH-1:0] product, prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  // op[0]=0 selects the signed variants (mult, div)
  assign is_signed_op = ~op[0];
  assign a_neg        = is_signed_op & a_in[WIDTH-1];
  assign b_neg        = is_signed_op & b_in[WIDTH-1];
  assign mag_a        = a_neg ? (-a_in) : a_in;
  assign mag_b        = b_neg ? (-b_in) : b_in;

  // acc holds the product high half / partial remainder; qp holds multiplier bits / quotient
  assign mul_sum  = {1'b0, acc_q} + (qp_q[0] ? {1'b0, mag_b_q} : '0);
  assign rem_sh   = {acc_q, qp_q[WIDTH-1]};
  assign rem_ge   = rem_sh >= {1'b0, mag_b_q};
  assign rem_diff = rem_sh[WIDTH-1:0] - mag_b_q;

  assign product  = {acc_q, qp_q};
  assign prod_fix = neg_res_q ? (-product) : product;
  assign quot_fix = neg_res_q ? (-qp_q) : qp_q;
  assign rem_fix  = neg_rem_q ? (-acc_q) : acc_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    acc_d      = acc_q;
    qp_d       = qp_q;
    mag_b_d    = mag_b_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          is_div_d  = op[1];
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg & op[1];
          mag_b_d   = mag_b;
          acc_d     = '0;
          qp_d      = mag_a;
          cnt_d     = CW'(WIDTH);
          if (op[1] && (b_in == '0)) begin
            div_zero_d = 1'b1;
            state_d    = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (is_div_q) begin
          acc_d = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
          qp_d  = {qp_q[WIDTH-2:0], rem_ge};
        end else begin
          acc_d = mul_sum[WIDTH:1];
          qp_d  = {mul_sum[0], qp_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (is_div_q) begin
          lo_d = quot_fix;
          hi_d = rem_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = DONE;
      end
      DONE: begin
        div_zero_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      acc_q      <= '0;
      qp_q       <= '0;
      mag_b_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      acc_q      <= acc_d;
      qp_q       <= qp_d;
      mag_b_q    <= mag_b_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign div_zero = div_zero_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule
